tag_record_decoder: RTL and testbench

Receives the raw timestamp records emitted by the event tagger (one-cycle strobe, no backpressure) and extends each 36-bit timer value to an absolute timestamp by counting wraparound records. Event records go into an internal FIFO and are presented downstream on a valid/ready stream. Pure wraparound records update the epoch and are consumed. The block sits between the tagger and the host readout path and absorbs readout stalls.

---
 rtl/tag_record_pkg.sv | 22 ++
 rtl/tag_record_if.sv | 25 ++
 rtl/tag_event_fifo.sv | 40 ++++
 rtl/tag_record_decoder.sv | 63 ++++++
 tb/tb_tag_record_decoder.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/tag_record_pkg.sv
// tag_record_pkg: record field layout and event-entry type shared by the tag record decoder
package tag_record_pkg;
  localparam int N_CHANNELS = 4;
  localparam int EPOCH_W = 28;
  localparam int FIFO_DEPTH = 16;
  localparam int TIMER_W = 36;
  localparam int REC_W = 43 + N_CHANNELS;
  localparam int TIME_W = TIMER_W + EPOCH_W;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CH_LSB = 36;
  localparam int RSV_LSB = CH_LSB + N_CHANNELS;
  localparam int RSV_W = 5;
  localparam int TYPE_BIT = 41 + N_CHANNELS;
  localparam int WRAP_BIT = 42 + N_CHANNELS;
  localparam logic REC_TYPE_EVENT = 1'b0;
  typedef struct packed {
    logic [EPOCH_W-1:0] epoch;
    logic [TIMER_W-1:0] timer;
    logic [N_CHANNELS-1:0] channels;
    logic wrap;
  } evt_t;
endpackage

// File: rtl/tag_record_if.sv
// tag_record_if: tagger record input, event stream output and status of the decoder
interface tag_record_if;
  import tag_record_pkg::*;
  logic [REC_W-1:0] rec_data;
  logic rec_valid;
  logic epoch_clear;
  logic status_clear;
  logic [TIME_W-1:0] evt_time;
  logic [N_CHANNELS-1:0] evt_channels;
  logic evt_wrap;
  logic evt_valid;
  logic evt_ready;
  logic [LVL_W-1:0] fifo_level;
  logic [15:0] overflow_count;
  logic fmt_err;
  logic synced;
  modport master (
    output rec_data, rec_valid, epoch_clear, status_clear, evt_ready,
    input evt_time, evt_channels, evt_wrap, evt_valid, fifo_level, overflow_count, fmt_err, synced
  );
  modport slave (
    input rec_data, rec_valid, epoch_clear, status_clear, evt_ready,
    output evt_time, evt_channels, evt_wrap, evt_valid, fifo_level, overflow_count, fmt_err, synced
  );
endinterface

// File: rtl/tag_event_fifo.sv
// tag_event_fifo: synchronous show-ahead FIFO; head is zero while empty
module tag_event_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wr,
  input  logic [W-1:0] i_data,
  input  logic i_rd,
  output logic [W-1:0] o_data,
  output logic o_valid,
  output logic o_full,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_pop, w_push;
  assign o_valid = r_cnt != '0;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_level = r_cnt;
  assign o_data = o_valid ? r_mem[r_rp] : '0;
  assign w_pop = i_rd && o_valid;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
  assign w_push = i_wr && (!o_full || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/tag_record_decoder.sv
// tag_record_decoder: validates tagger records, extends timers with a wrap-counted epoch
// and queues event records for the host readout stream
module tag_record_decoder
  import tag_record_pkg::*;
(
  input logic clk,
  input logic reset,
  tag_record_if.slave bus
);
  logic [EPOCH_W-1:0] r_epoch;
  logic r_synced, r_wr_en, r_fmt, r_fmt_err;
  logic [15:0] r_ovf;
  evt_t r_entry;
  evt_t w_head;
  logic [N_CHANNELS-1:0] w_ch;
  logic w_malformed, w_ok, w_wrap, w_full, w_valid, w_drop;
  logic [EPOCH_W-1:0] w_epoch_nx;
  logic w_synced_nx;
  assign w_ch = bus.rec_data[CH_LSB +: N_CHANNELS];
  assign w_wrap = bus.rec_data[WRAP_BIT];
  assign w_malformed = (bus.rec_data[RSV_LSB +: RSV_W] != '0) || (bus.rec_data[TYPE_BIT] != REC_TYPE_EVENT);
  assign w_ok = bus.rec_valid && !w_malformed;
  // the first wrap after reset or clear only establishes sync; later wraps advance the epoch
  assign w_epoch_nx = bus.epoch_clear ? '0 : (w_ok && w_wrap && r_synced) ? r_epoch + 1'b1 : r_epoch;
  assign w_synced_nx = bus.epoch_clear ? 1'b0 : (w_ok && w_wrap) ? 1'b1 : r_synced;
  assign w_drop = r_wr_en && w_full && !(w_valid && bus.evt_ready);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_epoch <= '0;
      r_synced <= 1'b0;
      r_wr_en <= 1'b0;
      r_fmt <= 1'b0;
      r_entry <= '0;
      r_fmt_err <= 1'b0;
      r_ovf <= '0;
    end else begin
      r_epoch <= w_epoch_nx;
      r_synced <= w_synced_nx;
      r_wr_en <= w_ok && (w_ch != '0);
      r_fmt <= bus.rec_valid && w_malformed;
      r_entry <= '{epoch: w_epoch_nx, timer: bus.rec_data[TIMER_W-1:0], channels: w_ch, wrap: w_wrap};
      r_fmt_err <= bus.status_clear ? 1'b0 : r_fmt_err || r_fmt;
      r_ovf <= bus.status_clear ? '0 : (w_drop && r_ovf != 16'hFFFF) ? r_ovf + 1'b1 : r_ovf;
    end
  tag_event_fifo #(.W($bits(evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_wr(r_wr_en),
    .i_data(r_entry),
    .i_rd(bus.evt_ready),
    .o_data(w_head),
    .o_valid(w_valid),
    .o_full(w_full),
    .o_level(bus.fifo_level)
  );
  assign bus.evt_time = {w_head.epoch, w_head.timer};
  assign bus.evt_channels = w_head.channels;
  assign bus.evt_wrap = w_head.wrap;
  assign bus.evt_valid = w_valid;
  assign bus.overflow_count = r_ovf;
  assign bus.fmt_err = r_fmt_err;
  assign bus.synced = r_synced;
endmodule

// File: tb/tb_tag_record_decoder.sv
// tb_tag_record_decoder: directed checks of decode, epoch extension, FIFO overflow and reset
module tb_tag_record_decoder;
  import tag_record_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  tag_record_if bus();
  tag_record_decoder dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [REC_W-1:0] mk(input logic [35:0] t, input logic [3:0] ch, input logic w,
                                          input logic [4:0] rsv = 5'd0, input logic ty = 1'b0);
    return {w, ty, rsv, ch, t};
  endfunction
  task automatic send(input logic [REC_W-1:0] r);
    bus.rec_data = r;
    bus.rec_valid = 1'b1;
    tick();
    bus.rec_valid = 1'b0;
    bus.rec_data = '0;
  endtask
  task automatic pop();
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
  endtask
  initial begin
    bus.rec_data = '0;
    bus.rec_valid = 1'b0;
    bus.epoch_clear = 1'b0;
    bus.status_clear = 1'b0;
    bus.evt_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.evt_valid, 0);
    chk("rst_time", bus.evt_time, 0);
    chk("rst_ch", bus.evt_channels, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_ovf", bus.overflow_count, 0);
    chk("rst_fmt", bus.fmt_err, 0);
    chk("rst_synced", bus.synced, 0);
    reset = 1'b0;
    tick();
    send(mk(36'h0, 4'h0, 1'b1));
    chk("sync_t1", bus.synced, 1);
    chk("wrap_no_entry", bus.fifo_level, 0);
    send(mk(36'h100, 4'b0010, 1'b0));
    chk("evt_not_yet_t1", bus.evt_valid, 0);
    tick();
    chk("evt_valid_t2", bus.evt_valid, 1);
    chk("evt1_time", bus.evt_time, 64'h0000_0000_0000_0100);
    chk("evt1_ch", bus.evt_channels, 4'b0010);
    chk("evt1_wrap", bus.evt_wrap, 0);
    chk("evt1_level", bus.fifo_level, 1);
    pop();
    chk("pop_level", bus.fifo_level, 0);
    chk("pop_valid", bus.evt_valid, 0);
    send(mk(36'h0, 4'h0, 1'b1));
    send(mk(36'h0, 4'h0, 1'b1));
    send(mk(36'h5, 4'b1000, 1'b0));
    tick();
    chk("epoch2_time", bus.evt_time, 64'h0000_0020_0000_0005);
    chk("epoch2_ch", bus.evt_channels, 4'b1000);
    chk("epoch2_level", bus.fifo_level, 1);
    pop();
    send(mk(36'h7, 4'b0001, 1'b1));
    tick();
    chk("wrapevt_time", bus.evt_time, 64'h0000_0030_0000_0007);
    chk("wrapevt_wrap", bus.evt_wrap, 1);
    chk("wrapevt_ch", bus.evt_channels, 4'b0001);
    pop();
    for (int i = 0; i < 20; i++) send(mk(36'(i), 4'b0100, 1'b0));
    tick();
    chk("full_level", bus.fifo_level, 16);
    chk("full_ovf", bus.overflow_count, 4);
    chk("full_head", bus.evt_time, {28'd3, 36'd0});
    send(mk(36'h99, 4'b0100, 1'b0));
    pop();
    chk("pushpop_level", bus.fifo_level, 16);
    chk("pushpop_ovf", bus.overflow_count, 4);
    bus.evt_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d", i), bus.evt_time, {28'd3, 36'(i)});
      tick();
    end
    chk("drain_last", bus.evt_time, {28'd3, 36'h99});
    tick();
    bus.evt_ready = 1'b0;
    chk("drain_level", bus.fifo_level, 0);
    chk("drain_valid", bus.evt_valid, 0);
    bus.status_clear = 1'b1;
    tick();
    bus.status_clear = 1'b0;
    chk("ovf_clear", bus.overflow_count, 0);
    send(mk(36'h10, 4'b0010, 1'b1, 5'b00001));
    send(mk(36'h11, 4'b0010, 1'b0, 5'd0, 1'b1));
    tick();
    tick();
    chk("fmt_err", bus.fmt_err, 1);
    chk("fmt_level", bus.fifo_level, 0);
    send(mk(36'h0, 4'b0001, 1'b0));
    tick();
    chk("fmt_epoch", bus.evt_time, 64'h0000_0030_0000_0000);
    pop();
    bus.status_clear = 1'b1;
    tick();
    bus.status_clear = 1'b0;
    chk("fmt_clear", bus.fmt_err, 0);
    bus.epoch_clear = 1'b1;
    for (int i = 0; i < 3; i++) send(mk(36'h0, 4'h0, 1'b1));
    chk("clear_synced", bus.synced, 0);
    bus.epoch_clear = 1'b0;
    send(mk(36'h0, 4'h0, 1'b1));
    chk("resync", bus.synced, 1);
    send(mk(36'h0, 4'h0, 1'b1));
    send(mk(36'h42, 4'b0100, 1'b0));
    tick();
    chk("clear_epoch1", bus.evt_time, 64'h0000_0010_0000_0042);
    pop();
    for (int i = 0; i < 3; i++) send(mk(36'(i + 1), 4'b0001, 1'b0));
    bus.rec_data = mk(36'h9, 4'b0001, 1'b0);
    bus.rec_valid = 1'b1;
    chk("burst_valid", bus.evt_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", bus.evt_valid, 0);
    chk("arst_level", bus.fifo_level, 0);
    chk("arst_synced", bus.synced, 0);
    bus.rec_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("arst_stays_empty", bus.fifo_level, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
